// File: rtl/dcache_controller.sv
// rtl/dcache_controller.sv - direct-mapped write-through no-allocate data cache controller
// Optional read hit/miss counters are built only when DCACHE_STATS_EN is defined.
module dcache_controller #(
   parameter int LINES       = 8,
   parameter int MEM_LATENCY = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         cpuRead,
   input  logic         cpuWrite,
   input  logic [31:0]  cpuAddr,
   input  logic [31:0]  cpuWData,
   output logic [31:0]  cpuRData,
   output logic         cpuReady,
   output logic [31:0]  memAddr,
   output logic         memWriteSig,
   output logic [31:0]  memInData,
   input  logic [127:0] memOut,
   output logic [31:0]  hitCount,
   output logic [31:0]  missCount
);
   localparam int IW = $clog2(LINES);
   localparam int TW = 30 - IW;
   localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

   typedef enum logic [1:0] {IDLE, FILL, WRITE, RESP} state_t;

   state_t          state, state_n;
   logic [CW-1:0]   cnt;
   logic [31:0]     req_addr;
   logic [31:0]     req_wdata;
   logic [LINES-1:0] valid_q;
   logic [TW-1:0]   tag_q  [LINES];
   logic [127:0]    data_q [LINES];

   logic [31:0]     look_addr;
   logic [IW-1:0]   look_idx;
   logic [TW-1:0]   look_tag;
   logic            hit;
   logic            last;

   // Lookups use the live address while idle and the latched request afterwards,
   // so a request dropped mid-access still completes against the right line.
   always_comb begin
      look_addr = (state == IDLE) ? cpuAddr : req_addr;
      look_idx  = look_addr[IW+1:2];
      look_tag  = look_addr[31:IW+2];
      hit       = valid_q[look_idx] && (tag_q[look_idx] == look_tag);
      last      = (cnt == CW'(MEM_LATENCY - 1));
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE: begin
            if (cpuWrite)     state_n = WRITE;
            else if (cpuRead) state_n = hit ? RESP : FILL;
         end
         FILL:    if (last) state_n = RESP;
         WRITE:   if (last) state_n = RESP;
         RESP:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   assign cpuReady = (state == RESP);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         req_addr    <= '0;
         req_wdata   <= '0;
         valid_q     <= '0;
         cpuRData    <= '0;
         memAddr     <= '0;
         memWriteSig <= 1'b0;
         memInData   <= '0;
      end else begin
         state <= state_n;
         cnt   <= ((state == FILL || state == WRITE) && !last) ? cnt + CW'(1) : '0;
         case (state)
            IDLE: begin
               if (cpuWrite) begin
                  req_addr    <= cpuAddr;
                  req_wdata   <= cpuWData;
                  memAddr     <= cpuAddr;
                  memInData   <= cpuWData;
                  memWriteSig <= 1'b1;
               end else if (cpuRead) begin
                  req_addr <= cpuAddr;
                  if (hit) cpuRData <= data_q[look_idx][{cpuAddr[1:0], 5'b0} +: 32];
                  else     memAddr  <= {cpuAddr[31:2], 2'b00};
               end
            end
            FILL: begin
               if (last) begin
                  valid_q[look_idx] <= 1'b1;
                  cpuRData          <= memOut[{req_addr[1:0], 5'b0} +: 32];
               end
            end
            WRITE:   if (last) memWriteSig <= 1'b0;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && state == FILL && last) begin
         tag_q[look_idx]  <= look_tag;
         data_q[look_idx] <= memOut;
      end else if (rst_n && state == WRITE && last && hit) begin
         data_q[look_idx][{req_addr[1:0], 5'b0} +: 32] <= req_wdata;
      end
   end

`ifdef DCACHE_STATS_EN
   logic [31:0] hit_q, miss_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hit_q  <= '0;
         miss_q <= '0;
      end else begin
         if (state == IDLE && !cpuWrite && cpuRead && hit && hit_q != 32'hFFFF_FFFF)
            hit_q <= hit_q + 32'd1;
         if (state == FILL && last && miss_q != 32'hFFFF_FFFF)
            miss_q <= miss_q + 32'd1;
      end
   end

   assign hitCount  = hit_q;
   assign missCount = miss_q;
`else
   assign hitCount  = 32'd0;
   assign missCount = 32'd0;
`endif
endmodule

// File: tb/tb_dcache_controller.sv
// tb/tb_dcache_controller.sv - directed bench for dcache_controller with a behavioural cache/memory model
module tb_dcache_controller;
   localparam int LINES = 8;
   localparam int L     = 2;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         cpuRead = 1'b0, cpuWrite = 1'b0;
   logic [31:0]  cpuAddr = '0, cpuWData = '0;
   logic [31:0]  cpuRData, memAddr, memInData, hitCount, missCount;
   logic         cpuReady, memWriteSig;
   logic [127:0] memOut;

   dcache_controller #(.LINES(LINES), .MEM_LATENCY(L)) dut (
      .clk(clk), .rst_n(rst_n), .cpuRead(cpuRead), .cpuWrite(cpuWrite),
      .cpuAddr(cpuAddr), .cpuWData(cpuWData), .cpuRData(cpuRData), .cpuReady(cpuReady),
      .memAddr(memAddr), .memWriteSig(memWriteSig), .memInData(memInData), .memOut(memOut),
      .hitCount(hitCount), .missCount(missCount)
   );

   always #5 clk = ~clk;

   // DataMemory stand-in, written only through the DUT's write port
   logic [31:0] dm [64];
   always @(posedge clk) if (memWriteSig) dm[memAddr[5:0]] <= memInData;
   always_comb begin
      memOut = '0;
      for (int w = 0; w < 4; w++) memOut[32*w +: 32] = dm[{memAddr[5:2], 2'(w)}];
   end

   // Reference model: what the cache and memory must contain
   logic [31:0] ref_mem [64];
   bit          mv [LINES];
   int unsigned mt [LINES];
   logic [31:0] md [LINES][4];
   int unsigned m_hits = 0, m_miss = 0;

   int vectors = 0, miscompares = 0;
   bit act = 0;
   int k = 0, lat = 0, last_lat = 0;
   bit is_hit = 0, is_wr = 0;
   logic [31:0] exp_maddr, exp_wdata, exp_data, last_rdata;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
      end
   endtask

   function automatic logic [31:0] exp_cnt(input int unsigned v);
`ifdef DCACHE_STATS_EN
      return v;
`else
      return 32'd0 + 32'(v & 0);
`endif
   endfunction

   always @(negedge clk) begin
      if (act) begin
         k++;
         chk("cpuReady", {31'd0, cpuReady}, {31'd0, k == lat});
         if (!is_hit && k <= L) begin
            chk("memAddr", memAddr, exp_maddr);
            chk("memWriteSig", {31'd0, memWriteSig}, {31'd0, is_wr});
            if (is_wr) chk("memInData", memInData, exp_wdata);
         end else begin
            chk("memWriteSig_idle", {31'd0, memWriteSig}, 32'd0);
         end
         if (k == lat) begin
            if (!is_wr) chk("cpuRData", cpuRData, exp_data);
            if (!is_hit) chk("memAddr_hold", memAddr, exp_maddr);
            chk("hitCount", hitCount, exp_cnt(m_hits));
            chk("missCount", missCount, exp_cnt(m_miss));
            last_rdata = cpuRData;
            last_lat   = k;
            act        = 0;
         end
      end else if (rst_n) begin
         chk("cpuReady_idle", {31'd0, cpuReady}, 32'd0);
         chk("memWriteSig_idle", {31'd0, memWriteSig}, 32'd0);
      end
   end

   // kind: 0 read, 1 write, 2 read and write together (behaves as write)
   task automatic access(input int kind, input logic [31:0] addr, input logic [31:0] wdata);
      int idx;
      int unsigned tag;
      idx = int'(addr[4:2]);
      tag = addr[31:5];
      @(negedge clk); #1;
      is_wr  = (kind != 0);
      is_hit = mv[idx] && (mt[idx] == tag);
      if (is_wr) begin
         exp_maddr = addr;
         exp_wdata = wdata;
         ref_mem[addr[5:0]] = wdata;
         if (is_hit) md[idx][addr[1:0]] = wdata;
         is_hit = 0;
         lat = L + 1;
      end else if (is_hit) begin
         exp_data = md[idx][addr[1:0]];
         m_hits++;
         lat = 1;
      end else begin
         exp_maddr = {addr[31:2], 2'b00};
         for (int w = 0; w < 4; w++) md[idx][w] = ref_mem[{addr[5:2], 2'(w)}];
         mv[idx] = 1;
         mt[idx] = tag;
         exp_data = md[idx][addr[1:0]];
         m_miss++;
         lat = L + 1;
      end
      cpuRead  = (kind != 1);
      cpuWrite = (kind != 0);
      cpuAddr  = addr;
      cpuWData = wdata;
      k = 0;
      act = 1;
      repeat (lat) @(negedge clk);
      #1;
      cpuRead = 0;
      cpuWrite = 0;
   endtask

   task automatic model_reset();
      for (int i = 0; i < LINES; i++) mv[i] = 0;
      m_hits = 0;
      m_miss = 0;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) begin
         dm[i] = 32'(3 * i);
         ref_mem[i] = 32'(3 * i);
      end
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_cpuReady", {31'd0, cpuReady}, 32'd0);
      chk("rst_memWriteSig", {31'd0, memWriteSig}, 32'd0);
      chk("rst_memAddr", memAddr, 32'd0);
      chk("rst_memInData", memInData, 32'd0);
      chk("rst_cpuRData", cpuRData, 32'd0);
      chk("rst_hitCount", hitCount, 32'd0);
      chk("rst_missCount", missCount, 32'd0);
      #1 rst_n = 1;

      access(0, 32'd5, 32'd0);
      chk("lit_miss_data", last_rdata, 32'd15);
      chk("lit_miss_lat", 32'(last_lat), 32'd3);
      chk("lit_missCount", missCount, exp_cnt(1));
      access(0, 32'd7, 32'd0);
      chk("lit_hit_data", last_rdata, 32'd21);
      chk("lit_hit_lat", 32'(last_lat), 32'd1);
      chk("lit_hitCount", hitCount, exp_cnt(1));

      access(1, 32'd5, 32'd7);
      chk("lit_write_lat", 32'(last_lat), 32'd3);
      access(0, 32'd5, 32'd0);
      chk("lit_write_hit_data", last_rdata, 32'd7);
      chk("lit_dm5", dm[5], 32'd7);

      access(1, 32'd20, 32'd15);
      access(0, 32'd20, 32'd0);
      chk("lit_noalloc_lat", 32'(last_lat), 32'd3);
      chk("lit_noalloc_data", last_rdata, 32'd15);

      access(0, 32'd0, 32'd0);
      access(0, 32'd32, 32'd0);
      chk("lit_conflict_data", last_rdata, 32'd96);
      access(0, 32'd0, 32'd0);
      chk("lit_conflict_lat", 32'(last_lat), 32'd3);

      access(2, 32'd6, 32'd99);
      access(0, 32'd6, 32'd0);
      chk("lit_both_data", last_rdata, 32'd99);
      access(0, 32'd4, 32'd0);
      access(0, 32'd4, 32'd0);

      @(negedge clk); #1;
      cpuRead = 1;
      cpuAddr = 32'd17;
      @(negedge clk); #1;
      chk("lit_fill_addr", memAddr, 32'd16);
      rst_n = 0;
      cpuRead = 0;
      model_reset();
      repeat (2) @(negedge clk);
      #1 rst_n = 1;
      repeat (4) @(negedge clk);
      chk("lit_post_rst_missCount", missCount, 32'd0);
      access(0, 32'd17, 32'd0);
      chk("lit_post_rst_lat", 32'(last_lat), 32'd3);
      chk("lit_post_rst_data", last_rdata, 32'd51);

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule

// File: doc/dcache_controller.md
# dcache_controller

Direct-mapped, write-through, no-write-allocate cache controller between the CPU pipeline's memory stage and DataMemory. It requests 4-word (128-bit) blocks from DataMemory on read misses and forwards every CPU store to DataMemory through the memory's single-word write port. It stalls the pipeline until each access completes.

## Interface
- LINES, 8: cache lines (power of two, ≥2); each line holds 4 words, one valid bit and a tag.
- MEM_LATENCY, 2: cycles DataMemory needs before `memOut` is valid, or before a write is committed (≥1).
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset. The design has one clock; reset is synchronous and active-low.
- cpuRead  in  1  load request; held by the CPU until `cpuReady`.
- cpuWrite  in  1  store request; held until `cpuReady`.
- cpuAddr  in  32  word address. [1:0] is the word offset, [1+log2(LINES):2] is the index, and the remaining upper bits are the tag.
- cpuWData  in  32  store data.
- cpuRData  out  32  load data, valid in the `cpuReady` cycle.
- cpuReady  out  1  one-cycle completion pulse.
- memAddr  out  32  DataMemory address.
- memWriteSig  out  1  DataMemory write enable.
- memInData  out  32  DataMemory write data.
- memOut  in  128  DataMemory block. Word k is at bits [32k+31:32k].
- hitCount  out  32  read-hit counter (see Configuration).
- missCount  out  32  read-miss counter.

## Operation
- **States:**
  - IDLE: waiting for a request.
  - FILL: a read miss is fetching its block from DataMemory.
  - WRITE: a store is being forwarded to DataMemory.
  - RESP: the access completes and `cpuReady` is driven.
- **IDLE, read:**
  - Hit (valid and tags equal): register the word and go to RESP.
  - Miss: go to FILL.
- **IDLE, write:** go to WRITE.
- **IDLE, both requests asserted:** treated as a write; the read is ignored.
- **FILL:**
  - `memAddr` = {cpuAddr[31:2], 2'b00} for MEM_LATENCY cycles.
  - In the last cycle, capture `memOut` into the line, set the tag and the valid bit, and select the requested word.
  - Then go to RESP.
- **WRITE:**
  - `memAddr` = cpuAddr, `memInData` = cpuWData, `memWriteSig` = 1 for MEM_LATENCY cycles.
  - On a hit, the cached word is updated in the final cycle.
  - On a miss, no line changes (no allocate).
  - Then go to RESP.
- **RESP:** `cpuReady` = 1 for one cycle, then return to IDLE. A new request is sampled no earlier than the next IDLE cycle.
- **Outside FILL and WRITE:** `memWriteSig` = 0 and `memAddr`/`memInData` hold their last values.
- **Conflict misses:** a miss to an index that already holds a valid line with a different tag overwrites that line.

## Timing
- **Reset values:** all outputs 0, state IDLE, all valid bits cleared, counters 0.
- **Read hit:** request seen at edge N → `cpuReady` pulse in cycle N+1 (latency 1).
- **Read miss:** `cpuReady` arrives MEM_LATENCY+1 cycles after the request edge.
- **Write:** `cpuReady` arrives MEM_LATENCY+1 cycles after the request edge, whether it hits or misses.
- **Reset mid-FILL:** the fill is abandoned and no line becomes valid.
- **Reset mid-WRITE:** `memWriteSig` is 0 from the next edge, and `cpuReady` is never pulsed for the aborted access.
- **Request dropped before `cpuReady`:** undefined at the interface. The controller still completes the access internally.
- **Back-to-back accesses:** minimum spacing of request-to-request is 2 cycles (hit, RESP, IDLE).

## Configuration
- DCACHE_STATS_EN defined:
  - `hitCount` increments on each read hit.
  - `missCount` increments on each read miss.
  - Both increment on entry to RESP, saturate at 32'hFFFF_FFFF, and clear on reset.
  - Writes are not counted.
- DCACHE_STATS_EN undefined: both ports are tied to 0 and no counter logic is instantiated.

## Test plan
- **Reset then read miss:** after reset, read addr 5 with memOut word1 = 15 → `memAddr` = 4 for 2 cycles, `cpuReady` at cycle 3, `cpuRData` = 15; `missCount` = 1.
- **Refill then hit:** read addr 7 after the previous access → `cpuReady` after 1 cycle, data = memOut word3 as captured, no memory access; `hitCount` = 1.
- **Write hit:** write 7 to addr 5 → `memWriteSig` = 1 for 2 cycles with `memAddr` = 5 and `memInData` = 7. A subsequent read of 5 hits and returns 7.
- **Write miss, no allocate:** write 15 to addr 20 → 2-cycle memory write. A subsequent read of 20 misses and fills from `memAddr` 20.
- **Conflict:** read addr 0 then addr 32 (same index, LINES=8) → both miss. A reread of 0 misses again.
- **Reset mid-fill:** assert rst_n = 0 in the FILL cycle of a miss to addr 17 → no `cpuReady`. A read of 17 after reset still misses.
